// File: rtl/cu_run_step_controller.sv
// cu_run_step_controller: operator run/step front end feeding the microsequencer.
// Define CYCLE_COUNTER_EN to add a saturating RUN-cycle counter on o_cycle_count.
module cu_run_step_controller #(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         CNT_W           = 16,
  parameter logic [6:0] FETCH_ADDR      = 7'h00,
  parameter logic [6:0] WAIT_ADDR       = 7'h20
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_btn_start,
  input  logic             i_btn_step,
  input  logic             i_sw_step_mode,
  input  logic             i_ctrl_halt,
  input  logic [6:0]       i_car_data,
  output logic             o_cpu_start,
  output logic             o_step_execution,
  output logic             o_next_instr_stimulus,
  output logic [1:0]       o_run_state,
  output logic [CNT_W-1:0] o_instr_count,
  output logic [31:0]      o_cycle_count
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0] DB_ONE  = DBW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b10
  } state_t;

  state_t         r_state;
  logic [1:0]     r_startSync;
  logic [1:0]     r_stepSync;
  logic [1:0]     r_modeSync;
  logic [DBW-1:0] r_dbCnt [2];
  logic [1:0]     r_btnLvl;
  logic [1:0]     r_btnLvlD;
  logic [6:0]     r_prevAddr;

  logic [1:0]     w_btnSync;
  logic           w_startP;
  logic           w_stepP;
  logic           w_fetchEdge;
  logic           w_atWait;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_startSync <= '0;
      r_stepSync  <= '0;
      r_modeSync  <= '0;
    end else begin
      r_startSync <= {r_startSync[0], i_btn_start};
      r_stepSync  <= {r_stepSync[0], i_btn_step};
      r_modeSync  <= {r_modeSync[0], i_sw_step_mode};
    end
  end

  assign w_btnSync = {r_stepSync[1], r_startSync[1]};

  // Index 0 is start, index 1 is step; any agreement with the accepted level reloads the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dbCnt   <= '{default: '0};
      r_btnLvl  <= '0;
      r_btnLvlD <= '0;
    end else begin
      r_btnLvlD <= r_btnLvl;
      for (int b = 0; b < 2; b++) begin
        if (w_btnSync[b] == r_btnLvl[b]) begin
          r_dbCnt[b] <= '0;
        end else if (r_dbCnt[b] == DB_LAST) begin
          r_btnLvl[b] <= w_btnSync[b];
          r_dbCnt[b]  <= '0;
        end else begin
          r_dbCnt[b] <= r_dbCnt[b] + DB_ONE;
        end
      end
    end
  end

  assign w_startP    = r_btnLvl[0] & ~r_btnLvlD[0];
  assign w_stepP     = r_btnLvl[1] & ~r_btnLvlD[1];
  assign w_fetchEdge = (i_car_data == FETCH_ADDR) && (r_prevAddr != FETCH_ADDR);
  assign w_atWait    = (i_car_data == WAIT_ADDR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state               <= S_IDLE;
      r_prevAddr            <= FETCH_ADDR;
      o_cpu_start           <= 1'b0;
      o_step_execution      <= 1'b0;
      o_next_instr_stimulus <= 1'b0;
      o_run_state           <= S_IDLE;
      o_instr_count         <= '0;
    end else begin
      r_prevAddr <= i_car_data;
      // Mode only changes between instructions, never while a micro-routine is in flight.
      if (r_state == S_IDLE || (r_state == S_RUN && w_atWait))
        o_step_execution <= r_modeSync[1];
      if (r_state == S_RUN && w_fetchEdge && o_instr_count != '1)
        o_instr_count <= o_instr_count + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          if (w_startP) begin
            r_state       <= S_RUN;
            o_run_state   <= S_RUN;
            o_cpu_start   <= 1'b1;
            o_instr_count <= '0;
          end
        end
        S_RUN: begin
          if (i_ctrl_halt) begin
            r_state               <= S_HALTED;
            o_run_state           <= S_HALTED;
            o_next_instr_stimulus <= 1'b0;
          end else if (w_startP) begin
            r_state               <= S_IDLE;
            o_run_state           <= S_IDLE;
            o_cpu_start           <= 1'b0;
            o_next_instr_stimulus <= 1'b0;
          end else if (o_next_instr_stimulus) begin
            if (w_fetchEdge)
              o_next_instr_stimulus <= 1'b0;
          end else if (w_stepP && o_step_execution) begin
            o_next_instr_stimulus <= 1'b1;
          end
        end
        S_HALTED: begin
          if (w_startP) begin
            r_state     <= S_IDLE;
            o_run_state <= S_IDLE;
            o_cpu_start <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          o_run_state <= S_IDLE;
          o_cpu_start <= 1'b0;
        end
      endcase
    end
  end

`ifdef CYCLE_COUNTER_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_cycle_count <= '0;
    else if (r_state == S_IDLE && w_startP)
      o_cycle_count <= '0;
    else if (r_state == S_RUN && o_cycle_count != 32'hFFFF_FFFF)
      o_cycle_count <= o_cycle_count + 32'd1;
  end
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_cu_run_step_controller.sv
// tb_cu_run_step_controller: directed and random stimulus; a reference model fills a
// scoreboard queue each clock and a separate monitor compares the DUT against it.
`timescale 1ns/1ps
module tb_cu_run_step_controller;

  localparam int DEB       = 4;
  localparam int CW        = 4;
  localparam int CMAX      = (1 << CW) - 1;
  localparam int ST_IDLE   = 0;
  localparam int ST_RUN    = 1;
  localparam int ST_HALTED = 2;
  localparam int WAITA     = 'h20;

  logic          clk = 1'b0;
  logic          rstN;
  logic          btnStart;
  logic          btnStep;
  logic          swMode;
  logic          ctrlHalt;
  logic [6:0]    carData;
  logic          cpuStart;
  logic          stepExec;
  logic          stim;
  logic [1:0]    runState;
  logic [CW-1:0] instrCount;
  logic [31:0]   cycleCount;

  cu_run_step_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CW),
    .FETCH_ADDR(7'h00),
    .WAIT_ADDR(7'h20)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_btn_start(btnStart),
    .i_btn_step(btnStep),
    .i_sw_step_mode(swMode),
    .i_ctrl_halt(ctrlHalt),
    .i_car_data(carData),
    .o_cpu_start(cpuStart),
    .o_step_execution(stepExec),
    .o_next_instr_stimulus(stim),
    .o_run_state(runState),
    .o_instr_count(instrCount),
    .o_cycle_count(cycleCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     cpuStart;
    bit     stepExec;
    bit     stim;
    int     runState;
    int     instrCount;
    longint cycleCount;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model state: operator-level view of the controller.
  int     mState;
  bit     mStepExec;
  bit     mPend;
  int     mCount;
  longint mCycles;
  bit     accStart, accStep, pulseStart, pulseStep;
  int     lastCar;
  bit     hStart[$], hStep[$], hMode[$];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit sampleAgo(input bit q[$], input int back);
    int idx;
    idx = q.size() - back;
    if (idx < 0) return 1'b0;
    return q[idx];
  endfunction

  // An accepted level flips once the last DEB synchronised samples all disagree with it.
  function automatic bit windowFlip(input bit q[$], input bit acc);
    for (int i = 0; i < DEB; i++)
      if (sampleAgo(q, 2 + i) == acc) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void modelReset();
    mState = ST_IDLE; mStepExec = 0; mPend = 0; mCount = 0; mCycles = 0;
    accStart = 0; accStep = 0; pulseStart = 0; pulseStep = 0; lastCar = 0;
    hStart.delete(); hStep.delete(); hMode.delete();
  endfunction

  function automatic void modelStep();
    bit sP, tP, fetchEdge, modeS, nPend, oldS, oldT;
    int nState;
    if (!rstN) begin
      modelReset();
      return;
    end
    sP        = pulseStart;
    tP        = pulseStep;
    fetchEdge = (carData == 7'h00) && (lastCar != 0);
    modeS     = sampleAgo(hMode, 2);
    nState    = mState;
    nPend     = mPend;
    if (mState == ST_RUN) begin
      if (fetchEdge && mCount < CMAX) mCount++;
      if (mCycles < 64'hFFFF_FFFF) mCycles++;
      if (mPend && fetchEdge) nPend = 0;
      else if (!mPend && tP && mStepExec) nPend = 1;
    end
    if (mState == ST_IDLE || (mState == ST_RUN && int'(carData) == WAITA))
      mStepExec = modeS;
    case (mState)
      ST_IDLE:   if (sP) begin nState = ST_RUN; mCount = 0; mCycles = 0; end
      ST_RUN:    if (ctrlHalt) nState = ST_HALTED; else if (sP) nState = ST_IDLE;
      default:   if (sP) nState = ST_IDLE;
    endcase
    if (nState != ST_RUN) nPend = 0;
    mState = nState;
    mPend  = nPend;
    oldS = accStart;
    oldT = accStep;
    if (windowFlip(hStart, accStart)) accStart = !accStart;
    if (windowFlip(hStep, accStep)) accStep = !accStep;
    pulseStart = accStart && !oldS;
    pulseStep  = accStep && !oldT;
    hStart.push_back(btnStart);
    hStep.push_back(btnStep);
    hMode.push_back(swMode);
    if (hStart.size() > DEB + 4) begin
      void'(hStart.pop_front());
      void'(hStep.pop_front());
      void'(hMode.pop_front());
    end
    lastCar = int'(carData);
  endfunction

  function automatic void pushExpected();
    exp_t e;
    e.cpuStart   = (mState != ST_IDLE);
    e.stepExec   = mStepExec;
    e.stim       = mPend;
    e.runState   = mState;
    e.instrCount = mCount;
`ifdef CYCLE_COUNTER_EN
    e.cycleCount = mCycles;
`else
    e.cycleCount = 0;
`endif
    expQ.push_back(e);
  endfunction

  task automatic applyStimulus(input bit rst, input bit bs, input bit bt, input bit sw,
                               input bit halt, input logic [6:0] car);
    @(negedge clk);
    rstN = rst; btnStart = bs; btnStep = bt; swMode = sw; ctrlHalt = halt; carData = car;
    @(posedge clk);
    modelStep();
    pushExpected();
  endtask

  task automatic hold(input int n, input bit bs, input bit bt, input bit sw,
                      input bit halt, input logic [6:0] car);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, bs, bt, sw, halt, car);
  endtask

  // Monitor: compares every scoreboard entry against the settled DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("cpu_start", cpuStart, e.cpuStart);
        checkOutput("step_execution", stepExec, e.stepExec);
        checkOutput("next_instr_stimulus", stim, e.stim);
        checkOutput("run_state", runState, e.runState);
        checkOutput("instr_count", instrCount, e.instrCount);
        checkOutput("cycle_count", cycleCount, e.cycleCount);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [6:0] carSet [8];
    bit bs, bt, sw, bsc, btc;
    int len;
    carSet = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h20, 7'h20, 7'h05, 7'h00};
    rstN = 0; btnStart = 0; btnStep = 0; swMode = 0; ctrlHalt = 0; carData = 7'h00;
    modelReset();

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 0, 0, 7'h00);
    #1;
    checkOutput("reset_cpu_start", cpuStart, 0);
    checkOutput("reset_run_state", runState, 0);

    $display("[TB] start latency");
    hold(6, 1, 0, 0, 0, 7'h00);
    #1 checkOutput("start_latency_6", cpuStart, 0);
    hold(1, 1, 0, 0, 0, 7'h00);
    #1;
    checkOutput("start_latency_7", cpuStart, 1);
    checkOutput("start_run_state", runState, 1);
    checkOutput("start_instr_count", instrCount, 0);
    hold(3, 1, 0, 0, 0, 7'h00);
    hold(8, 0, 0, 0, 0, 7'h00);

    $display("[TB] auto-mode instruction count and halt");
    for (int r = 0; r < 2; r++)
      for (int a = 1; a <= 4; a++) hold(1, 0, 0, 0, 0, 7'(a % 4));
    #1 checkOutput("count_after_fetches", instrCount, 2);
    hold(1, 0, 0, 0, 1, 7'h00);
    for (int a = 1; a <= 4; a++) hold(1, 0, 0, 0, 0, 7'(a % 4));
    #1;
    checkOutput("halted_run_state", runState, 2);
    checkOutput("halted_cpu_start", cpuStart, 1);
    checkOutput("halted_count_frozen", instrCount, 2);

    $display("[TB] bounce on start");
    hold(6, 1, 0, 0, 0, 7'h00);
    hold(6, 0, 0, 1, 0, 7'h20);
    hold(1, 1, 0, 1, 0, 7'h20);
    hold(1, 0, 0, 1, 0, 7'h20);
    hold(1, 1, 0, 1, 0, 7'h20);
    hold(1, 0, 0, 1, 0, 7'h20);
    hold(8, 1, 0, 1, 0, 7'h20);
    hold(8, 0, 0, 1, 0, 7'h20);
    #1 checkOutput("bounce_single_run", runState, 1);

    $display("[TB] step stimulus");
    hold(6, 0, 1, 1, 0, 7'h20);
    hold(6, 0, 0, 1, 0, 7'h20);
    hold(6, 0, 1, 1, 0, 7'h20);
    hold(6, 0, 0, 1, 0, 7'h20);
    #1 checkOutput("stim_pending", stim, 1);
    hold(1, 0, 0, 1, 0, 7'h00);
    #1 checkOutput("stim_cleared", stim, 0);
    hold(4, 0, 0, 1, 0, 7'h20);
    #1 checkOutput("stim_no_requeue", stim, 0);

    $display("[TB] mode switch mid-instruction");
    hold(4, 0, 0, 0, 0, 7'h20);
    hold(6, 0, 0, 1, 0, 7'h05);
    #1 checkOutput("mode_held_mid_instr", stepExec, 0);
    hold(1, 0, 0, 1, 0, 7'h20);
    #1 checkOutput("mode_loaded_at_wait", stepExec, 1);

    $display("[TB] asynchronous reset with stimulus pending");
    hold(8, 0, 1, 1, 0, 7'h20);
    #1 checkOutput("stim_before_reset", stim, 1);
    #2 rstN = 0;
    #1;
    checkOutput("async_rst_cpu_start", cpuStart, 0);
    checkOutput("async_rst_stim", stim, 0);
    checkOutput("async_rst_step_exec", stepExec, 0);
    checkOutput("async_rst_run_state", runState, 0);
    checkOutput("async_rst_count", instrCount, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 0, 0, 0, 0, 7'h00);

    $display("[TB] RUN cycle counting");
    hold(7, 1, 0, 0, 0, 7'h00);
    for (int i = 0; i < 50; i++) hold(1, 1, 0, 0, 0, 7'(i % 3));
    #1;
`ifdef CYCLE_COUNTER_EN
    checkOutput("cycle_count_50", cycleCount, 50);
`else
    checkOutput("cycle_count_tied", cycleCount, 0);
`endif
    hold(8, 0, 0, 0, 0, 7'h00);

    $display("[TB] random traffic");
    sw = 0;
    for (int s = 0; s < 400; s++) begin
      bs  = ($urandom_range(0, 2) == 0);
      bt  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) sw = $urandom_range(0, 1);
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++) begin
        bsc = bs ^ ($urandom_range(0, 15) == 0);
        btc = bt ^ ($urandom_range(0, 15) == 0);
        applyStimulus($urandom_range(0, 600) != 0, bsc, btc, sw,
                      $urandom_range(0, 120) == 0, carSet[$urandom_range(0, 7)]);
      end
    end
    hold(5, 0, 0, 0, 0, 7'h00);
    #3 checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
